// File: rtl/ram_asym_write_packer_pkg.sv
// Shared types and helpers for the asymmetric RAM write packer.
// Default geometry matches the scratchpad: 10-bit narrow words, 4 per wide entry.
package ram_asym_pkg;

  localparam int DATA_WIDTH_DEF = 10;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int RATIO_DEF      = 4;
  localparam int LEN_WIDTH_DEF  = 16;
  localparam int LANE_W         = $clog2(RATIO_DEF);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PACK,
    ST_LAST,
    ST_DONE
  } state_t;

  // One-hot lane enable; callers truncate to their own ratio.
  function automatic logic [31:0] lane_sel(input logic [31:0] lane);
    return 32'h1 << lane;
  endfunction

endpackage

// File: rtl/ram_asym_write_packer_if.sv
// Narrow input stream plus wide RAM write-side bus of the packer.
// master = packer side, slave = producer/RAM side.
interface ram_asym_write_packer_if
  import ram_asym_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH_IN  = ADDR_WIDTH_DEF,
  parameter int BITWIDTH_RATIO = RATIO_DEF
);

  logic                                 s_valid;
  logic                                 s_ready;
  logic [DATA_WIDTH-1:0]                s_data;
  logic                                 m_write_req;
  logic [ADDR_WIDTH_IN-1:0]             m_write_addr;
  logic [BITWIDTH_RATIO*DATA_WIDTH-1:0] m_write_data;

  modport master (
    input  s_valid, s_data,
    output s_ready, m_write_req, m_write_addr, m_write_data
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, m_write_req, m_write_addr, m_write_data
  );

endinterface

// File: rtl/ram_asym_write_packer_lane_reg.sv
// Wide pack register: per-lane write enables, synchronous clear wins over writes.
// One-cycle write latency; no flow control of its own.
module ram_asym_lane_reg #(
  parameter int DATA_WIDTH = 10,
  parameter int RATIO      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic [RATIO-1:0]            wr_en,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  output logic [RATIO*DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q <= '0;
    end else begin
      for (int i = 0; i < RATIO; i++) begin
        if (wr_en[i]) q[i*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/ram_asym_write_packer.sv
// Packs BITWIDTH_RATIO narrow beats per wide RAM write; write_req rises the cycle after the completing beat.
// s_ready is high for all of PACK (RAM never stalls); RAM_PACKER_STATS_EN adds a saturating wr_count.
module ram_asym_write_packer
  import ram_asym_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH_IN  = ADDR_WIDTH_DEF,
  parameter int BITWIDTH_RATIO = RATIO_DEF,
  parameter int LEN_WIDTH      = LEN_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_WIDTH_IN-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]     num_words,
  output logic                     busy,
  output logic                     done,
  ram_asym_write_packer_if.master  bus
`ifdef RAM_PACKER_STATS_EN
  ,
  output logic [ADDR_WIDTH_IN:0]   wr_count
`endif
);

  localparam int LW = (BITWIDTH_RATIO == RATIO_DEF) ? LANE_W : $clog2(BITWIDTH_RATIO);
  localparam int WW = BITWIDTH_RATIO * DATA_WIDTH;

  state_t                   state;
  logic [LW-1:0]            lane_cnt;
  logic [LEN_WIDTH-1:0]     remaining;
  logic [ADDR_WIDTH_IN-1:0] wide_addr;
  logic [WW-1:0]            pack_q;
  logic [WW-1:0]            merged;
  logic [BITWIDTH_RATIO-1:0] lane_en;
  logic                     beat;
  logic                     lane_last;
  logic                     final_beat;
  logic                     emit;
  logic                     cmd_accept;
  logic                     pack_clear;

  assign bus.s_ready = (state == ST_PACK);
  assign beat        = bus.s_valid && bus.s_ready;
  assign lane_last   = (lane_cnt == LW'(BITWIDTH_RATIO - 1));
  assign final_beat  = (remaining == LEN_WIDTH'(1));
  assign emit        = beat && (lane_last || final_beat);
  assign cmd_accept  = (state == ST_IDLE) && start;
  assign pack_clear  = cmd_accept || emit;
  assign lane_en     = beat ? BITWIDTH_RATIO'(lane_sel(32'(lane_cnt))) : '0;

  // The completing beat is merged here so the write can leave one cycle after it.
  always_comb begin
    merged = pack_q;
    for (int i = 0; i < BITWIDTH_RATIO; i++) begin
      if (lane_en[i]) merged[i*DATA_WIDTH +: DATA_WIDTH] = bus.s_data;
    end
  end

  ram_asym_lane_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .RATIO     (BITWIDTH_RATIO)
  ) u_lane_reg (
    .clk    (clk),
    .reset  (reset),
    .clear  (pack_clear),
    .wr_en  (lane_en),
    .wr_data(bus.s_data),
    .q      (pack_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      lane_cnt         <= '0;
      remaining        <= '0;
      wide_addr        <= '0;
      bus.m_write_req  <= 1'b0;
      bus.m_write_addr <= '0;
      bus.m_write_data <= '0;
    end else begin
      bus.m_write_req <= 1'b0;
      done            <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            lane_cnt <= '0;
            if (num_words != '0) begin
              wide_addr <= base_addr;
              remaining <= num_words;
              state     <= ST_PACK;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_PACK: begin
          if (beat) begin
            remaining <= remaining - LEN_WIDTH'(1);
            if (emit) begin
              bus.m_write_req  <= 1'b1;
              bus.m_write_addr <= wide_addr;
              bus.m_write_data <= merged;
              wide_addr        <= wide_addr + ADDR_WIDTH_IN'(1);
              lane_cnt         <= '0;
              if (final_beat) state <= ST_LAST;
            end else begin
              lane_cnt <= lane_cnt + LW'(1);
            end
          end
        end
        ST_LAST: begin
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef RAM_PACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || cmd_accept) begin
      wr_count <= '0;
    end else if (bus.m_write_req && (wr_count != '1)) begin
      wr_count <= wr_count + (ADDR_WIDTH_IN + 1)'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ram_asym_write_packer.sv
// Directed bench: expected wide writes are queued by stimulus, a negedge monitor pops and compares.
module tb_ram_asym_write_packer;

  typedef struct packed {
    logic [9:0]  addr;
    logic [39:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [15:0] num_words = '0;
  logic        busy;
  logic        done;
`ifdef RAM_PACKER_STATS_EN
  logic [10:0] wr_count;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  wr_t exp_q[$];
  wr_t mon_e;
  logic [9:0] beats[8];

  ram_asym_write_packer_if #(.DATA_WIDTH(10), .ADDR_WIDTH_IN(10), .BITWIDTH_RATIO(4)) bus ();

  ram_asym_write_packer #(
    .DATA_WIDTH(10), .ADDR_WIDTH_IN(10), .BITWIDTH_RATIO(4), .LEN_WIDTH(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base_addr(base_addr),
    .num_words(num_words),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
`ifdef RAM_PACKER_STATS_EN
    ,
    .wr_count (wr_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bus.m_write_req) begin
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual addr=%h data=%h required none",
                 bus.m_write_addr, bus.m_write_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 64'(bus.m_write_addr), 64'(mon_e.addr));
        chk("wr_data", 64'(bus.m_write_data), 64'(mon_e.data));
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic send_cmd(input logic [9:0] b, input logic [15:0] n);
    start = 1'b1; base_addr = b; num_words = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Streams beats[first..last]; with stall set, valid is low every other cycle.
  task automatic stream(input int first, input int last, input bit stall);
    bit toggle = stall;
    for (int i = first; i <= last; i++) begin
      bit acc = 1'b0;
      int guard = 0;
      bus.s_data = beats[i];
      while (!acc && guard < 50) begin
        bus.s_valid = stall ? ~toggle : 1'b1;
        toggle = ~toggle;
        @(negedge clk);
        acc = bus.s_valid && bus.s_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!acc) chk("beat_accept_timeout", 64'(acc), 64'd1);
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (n < 60) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    chk(name, 64'(done), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_s_ready"}, 64'(bus.s_ready), 64'd0);
    chk({tag, "_write_req"}, 64'(bus.m_write_req), 64'd0);
    chk({tag, "_write_addr"}, 64'(bus.m_write_addr), 64'd0);
    chk({tag, "_write_data"}, 64'(bus.m_write_data), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bcnt;
    int dcnt;
    int d0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;

    // Full words, back-to-back
    for (int i = 0; i < 8; i++) beats[i] = 10'(i + 1);
    exp_q.push_back('{addr: 10'h010, data: {10'd4, 10'd3, 10'd2, 10'd1}});
    exp_q.push_back('{addr: 10'h011, data: {10'd8, 10'd7, 10'd6, 10'd5}});
    send_cmd(10'h010, 16'd8);
    stream(0, 7, 1'b0);
    wait_done("full_done");
    chk("full_done_after_last_write", 64'(done_cyc - last_wr_cyc), 64'd1);
    chk("full_queue_drained", 64'(exp_q.size()), 64'd0);
`ifdef RAM_PACKER_STATS_EN
    chk("full_wr_count", 64'(wr_count), 64'd2);
`endif
    @(negedge clk);
    chk("full_busy_low", 64'(busy), 64'd0);
    @(posedge clk); #1;

    // Partial tail
    for (int i = 0; i < 8; i++) beats[i] = 10'h3FF;
    exp_q.push_back('{addr: 10'h020, data: 40'hFF_FFFF_FFFF});
    exp_q.push_back('{addr: 10'h021, data: 40'h00_0000_03FF});
    send_cmd(10'h020, 16'd5);
    stream(0, 4, 1'b0);
    wait_done("tail_done");
    chk("tail_queue_drained", 64'(exp_q.size()), 64'd0);

    // Zero length
    start = 1'b1; num_words = 16'd0; base_addr = 10'h3AA;
    @(posedge clk); #1;
    start = 1'b0;
    bcnt = 0; dcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) chk("zero_done_first_cycle", 64'(done), 64'd1);
      if (busy) bcnt++;
      if (done) dcnt++;
      @(posedge clk); #1;
    end
    chk("zero_busy_cycles", 64'(bcnt), 64'd1);
    chk("zero_done_pulses", 64'(dcnt), 64'd1);
`ifdef RAM_PACKER_STATS_EN
    chk("zero_wr_count", 64'(wr_count), 64'd0);
`endif

    // Address wrap with 50% valid
    for (int i = 0; i < 8; i++) beats[i] = 10'(10'h101 + i);
    exp_q.push_back('{addr: 10'h3FF, data: {10'h104, 10'h103, 10'h102, 10'h101}});
    exp_q.push_back('{addr: 10'h000, data: {10'h108, 10'h107, 10'h106, 10'h105}});
    send_cmd(10'h3FF, 16'd8);
    stream(0, 7, 1'b1);
    wait_done("wrap_done");
    chk("wrap_queue_drained", 64'(exp_q.size()), 64'd0);

    // Reset after two beats
    for (int i = 0; i < 8; i++) beats[i] = 10'(10'h0A + i);
    send_cmd(10'h050, 16'd8);
    stream(0, 1, 1'b0);
    d0 = done_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midreset");
    repeat (5) @(posedge clk);
    #1;
    chk("midreset_no_done", 64'(done_cnt - d0), 64'd0);
    exp_q.push_back('{addr: 10'h060, data: {10'h00D, 10'h00C, 10'h00B, 10'h00A}});
    send_cmd(10'h060, 16'd4);
    stream(0, 3, 1'b0);
    wait_done("after_reset_done");
    chk("after_reset_queue_drained", 64'(exp_q.size()), 64'd0);

    // start while busy is ignored
    for (int i = 0; i < 8; i++) beats[i] = 10'(10'h21 + i);
    exp_q.push_back('{addr: 10'h100, data: {10'h024, 10'h023, 10'h022, 10'h021}});
    exp_q.push_back('{addr: 10'h101, data: {10'h028, 10'h027, 10'h026, 10'h025}});
    send_cmd(10'h100, 16'd8);
    stream(0, 2, 1'b0);
    d0 = done_cnt;
    send_cmd(10'h200, 16'd4);
    stream(3, 7, 1'b0);
    wait_done("busy_start_done");
    repeat (6) @(posedge clk);
    #1;
    chk("busy_start_single_done", 64'(done_cnt - d0), 64'd1);
`ifdef RAM_PACKER_STATS_EN
    chk("busy_start_wr_count", 64'(wr_count), 64'd2);
`endif
    chk("final_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
